ysyx_23060187_ifu: RTL and testbench
====================================

# ysyx_23060187_ifu

Instruction fetch unit for the ysyx_23060187 single-issue core, sitting between the PC register and instruction memory. It takes the current PC and issues a read request to instruction memory over a valid/ready address/data handshake. It then presents the returned instruction to the decode stage with a valid/ready handshake. When decode accepts the instruction, it pulses `pc_en` so the PC register advances. It is the fetch-side consumer of the PC register's `pc_out` and the source of the PC register's update enable.

## Interface
- `ALIGN_CHECK`, default 1: when 1, a PC with `pc[1:0]!=0` faults without issuing a memory request.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `pc_in`  in  32  current PC from PC register
- `pc_en`  out  1  one-cycle pulse; PC register advances on the same clock edge
- `imem_arvalid`  out  1  fetch address valid
- `imem_araddr`  out  32  fetch address
- `imem_arready`  in  1  memory accepts address
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  32  instruction word
- `imem_rresp`  in  2  response; 2'b00 OK, anything else is an error
- `imem_rready`  out  1  IFU accepts read data
- `inst_valid`  out  1  instruction available to decode
- `inst`  out  32  instruction word (0 on fault)
- `inst_pc`  out  32  PC of `inst`
- `inst_fault`  out  1  fetch error (misaligned or `rresp!=0`)
- `inst_ready`  in  1  decode accepts instruction

## Operation
- Four-state FSM: IDLE, REQ, WAIT, HOLD. Reset state is IDLE.
- On reset, all outputs are 0; `pc_q`, `inst_q` and `fault_q` are 0.
- **IDLE:**
  - capture `pc_q <= pc_in`.
  - Go to HOLD with `fault_q<=1` and `inst_q<=0` if `ALIGN_CHECK` and `pc_in[1:0]!=0`.
  - Otherwise go to REQ.
- **REQ:**
  - `imem_arvalid=1`, `imem_araddr=pc_q`.
  - On `imem_arready`, go to WAIT.
  - `imem_araddr` stays stable while `imem_arvalid` is high; `imem_arvalid` is never dropped before `imem_arready`.
- **WAIT:**
  - `imem_rready=1`.
  - On `imem_rvalid`, latch `inst_q<=(imem_rresp==0)?imem_rdata:0` and `fault_q<=(imem_rresp!=0)`, then go to HOLD.
- **HOLD:**
  - `inst_valid=1`, `inst=inst_q`, `inst_pc=pc_q`, `inst_fault=fault_q`.
  - On `inst_ready`, `pc_en=1` combinationally in that cycle, then go to IDLE.
- Outputs are decoded from state only, except `pc_en`, which is `(state==HOLD)&inst_ready`.
- Faulted instructions are delivered like normal ones and still pulse `pc_en`; trap handling is the consumer's job.
- At most one outstanding memory transaction.

## Timing
- Minimum 4 cycles per instruction: IDLE, REQ (`arready` same cycle), WAIT (`rvalid` same cycle), HOLD (`inst_ready` same cycle).
- A misaligned PC takes 2 cycles: IDLE, then HOLD.
- `pc_en` acts on the edge that leaves HOLD. The following IDLE cycle samples the updated `pc_in`, so no stale-PC fetch is possible.
- `imem_rvalid` outside WAIT is ignored, since `imem_rready=0`.
- `imem_arready` outside REQ is ignored.
- `inst_ready` outside HOLD has no effect, and `pc_en` stays 0.
- Back-pressure from either side holds the FSM in its state indefinitely with all outputs stable.
- `rst` in any state forces IDLE and zeroed outputs on the next edge.
  - A memory response pending at reset is the memory's responsibility; memory shares `rst`.
  - After reset, the IFU ignores `imem_rvalid` until it next reaches WAIT.
- `rst` has priority over every handshake in the same cycle.

## Test plan
- **Normal fetch:**
  - Stimulus: release reset with `pc_in=0x80000000`; memory holds `arready=1` and asserts `rvalid` in the first WAIT cycle with `rdata=0x00000413`, `rresp=0`; `inst_ready=1`.
  - Required: `arvalid` in cycle 2 with `araddr=0x80000000`; `inst_valid` in cycle 4 with `inst=0x00000413`, `inst_pc=0x80000000`, `inst_fault=0`; `pc_en` pulses exactly once in cycle 4.
- **Address back-pressure:**
  - Stimulus: `arready` low for 3 cycles.
  - Required: `arvalid=1` and `araddr` constant for all 4 REQ cycles; exactly one transfer.
- **Decode back-pressure:**
  - Stimulus: `inst_ready` low for 5 cycles while in HOLD.
  - Required: `inst_valid`, `inst` and `inst_pc` stable for all 5 cycles; `pc_en=0` throughout; single `pc_en` pulse when `inst_ready` rises.
- **Bus error:**
  - Stimulus: `rresp=2'b10` with `rdata=0xDEADBEEF`.
  - Required: `inst_fault=1`, `inst=0x00000000`; `pc_en` still pulses on acceptance.
- **Misaligned PC:**
  - Stimulus: `pc_in=0x80000002`.
  - Required: `imem_arvalid` never asserted; `inst_valid` in cycle 2 with `inst_fault=1` and `inst_pc=0x80000002`.
- **Reset mid-fetch:**
  - Stimulus: assert `rst` during WAIT, then drive `rvalid` one cycle after reset is released.
  - Required: all outputs 0 the cycle after `rst`; the stray `rvalid` is ignored; a fresh fetch of the current `pc_in` starts normally.

Source files
------------

// File: rtl/ysyx_23060187_ifu_if.sv
// Fetch-side bundle: PC register link, instruction-memory read channel and decode handshake.
// Every valid/ready pair transfers on a rising edge where both are high; a raised valid holds its payload until ready.
interface ysyx_23060187_ifu_if;
  logic [31:0] pc_in;
  logic        pc_en;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_ready;

  modport master (
    input  pc_in, imem_arready, imem_rvalid, imem_rdata, imem_rresp, inst_ready,
    output pc_en, imem_arvalid, imem_araddr, imem_rready, inst_valid, inst, inst_pc, inst_fault
  );

  modport slave (
    output pc_in, imem_arready, imem_rvalid, imem_rdata, imem_rresp, inst_ready,
    input  pc_en, imem_arvalid, imem_araddr, imem_rready, inst_valid, inst, inst_pc, inst_fault
  );
endinterface

// File: rtl/ysyx_23060187_ifu.sv
// Instruction fetch unit: one memory read per PC, result held for decode, pc_en pulsed on acceptance.
// Four-state FSM (IDLE/REQ/WAIT/HOLD); the current state is visible on dbg_state_o.
module ysyx_23060187_ifu #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_23060187_ifu_if.master           bus,
  output logic [1:0]                    dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= 32'h0;
      inst_q  <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        // PC is sampled here, after the previous pc_en edge, so it is never stale.
        pc_d = bus.pc_in;
        if (ALIGN_CHECK && (bus.pc_in[1:0] != 2'b00)) begin
          fault_d = 1'b1;
          inst_d  = 32'h0;
          state_d = HOLD;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.imem_arready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          inst_d  = (bus.imem_rresp == 2'b00) ? bus.imem_rdata : 32'h0;
          fault_d = (bus.imem_rresp != 2'b00);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.inst_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on state only; pc_en is the one handshake-qualified exception.
  always_comb begin
    bus.imem_arvalid = 1'b0;
    bus.imem_araddr  = 32'h0;
    bus.imem_rready  = 1'b0;
    bus.inst_valid   = 1'b0;
    bus.inst         = 32'h0;
    bus.inst_pc      = 32'h0;
    bus.inst_fault   = 1'b0;
    bus.pc_en        = 1'b0;
    unique case (state_q)
      REQ: begin
        bus.imem_arvalid = 1'b1;
        bus.imem_araddr  = pc_q;
      end
      WAIT: begin
        bus.imem_rready = 1'b1;
      end
      HOLD: begin
        bus.inst_valid = 1'b1;
        bus.inst       = inst_q;
        bus.inst_pc    = pc_q;
        bus.inst_fault = fault_q;
        bus.pc_en      = bus.inst_ready;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
// Self-checking bench for ysyx_23060187_ifu: directed fetch scenarios plus a short random run.
module tb_ysyx_23060187_ifu;

  localparam int W = 65;  // {fault, pc, inst}

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  ysyx_23060187_ifu_if bus ();

  ysyx_23060187_ifu #(.ALIGN_CHECK(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int ar_hs_cnt = 0;
  int pc_en_cnt = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: handshake counters and scoreboard pop on decode acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_arvalid && bus.imem_arready) ar_hs_cnt++;
      if (bus.pc_en) pc_en_cnt++;
      if (bus.inst_valid && bus.inst_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_inst", {bus.inst_fault, bus.inst_pc, bus.inst}, '0);
        end else begin
          check("sb_inst", {bus.inst_fault, bus.inst_pc, bus.inst}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_arready = 1'b0;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.imem_rresp   = 2'b00;
    bus.inst_ready   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"},
          {32'h0, bus.pc_en, bus.imem_arvalid, bus.imem_rready, bus.inst_valid, bus.inst_fault},
          '0);
    check({tag, "_buses"}, {1'b0, bus.imem_araddr, bus.inst}, '0);
    check({tag, "_inst_pc"}, {33'h0, bus.inst_pc}, '0);
  endtask

  // Starts in the IDLE cycle (just after a rising edge) and ends just after the edge leaving HOLD.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] rdata, input logic [1:0] rresp,
                       input int ar_wait, input int r_wait, input int rd_wait);
    logic         mis;
    logic         flt;
    logic [31:0]  exp_inst;
    int           ar0, pe0;
    mis      = (pc[1:0] != 2'b00);
    flt      = mis || (rresp != 2'b00);
    exp_inst = flt ? 32'h0 : rdata;
    ar0 = ar_hs_cnt;
    pe0 = pc_en_cnt;
    exp_q.push_back({flt, pc, exp_inst});

    // IDLE: a high inst_ready here must not pulse pc_en.
    idle_inputs();
    bus.pc_in      = pc;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check("idle_state", {63'h0, dbg_state}, 65'd0);
    check_all_zero("idle");
    step();
    bus.inst_ready = 1'b0;

    if (!mis) begin
      for (int i = 0; i <= ar_wait; i++) begin
        bus.imem_arready = (i == ar_wait);
        bus.imem_rvalid  = 1'b1;            // stray response, must be ignored in REQ
        bus.imem_rdata   = 32'hBADBAD00;
        bus.imem_rresp   = 2'b00;
        @(negedge clk);
        check("req_ar", {bus.imem_arvalid, bus.imem_araddr, bus.imem_rready, bus.inst_valid, 30'h0},
              {1'b1, pc, 1'b0, 1'b0, 30'h0});
        step();
      end
      bus.imem_arready = 1'b0;
      for (int i = 0; i <= r_wait; i++) begin
        bus.imem_rvalid = (i == r_wait);
        bus.imem_rdata  = (i == r_wait) ? rdata : 32'hBADBAD01;
        bus.imem_rresp  = rresp;
        bus.imem_arready = 1'b1;            // ignored outside REQ
        @(negedge clk);
        check("wait_r", {bus.imem_rready, bus.imem_arvalid, bus.inst_valid, 62'h0}, {3'b100, 62'h0});
        step();
      end
    end

    idle_inputs();
    for (int i = 0; i <= rd_wait; i++) begin
      bus.inst_ready   = (i == rd_wait);
      bus.imem_rvalid  = 1'b1;              // ignored in HOLD
      bus.imem_rdata   = 32'h12345678;
      bus.imem_arready = 1'b1;
      @(negedge clk);
      check("hold_inst", {bus.inst_fault, bus.inst_pc, bus.inst}, {flt, pc, exp_inst});
      check("hold_valid_pcen", {63'h0, bus.inst_valid, bus.pc_en}, {63'h0, 1'b1, (i == rd_wait)});
      check("hold_no_ar", {64'h0, bus.imem_arvalid}, '0);
      step();
    end
    idle_inputs();
    check("ar_transfers", W'(ar_hs_cnt - ar0), W'(mis ? 0 : 1));
    check("pc_en_pulses", W'(pc_en_cnt - pe0), W'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.pc_in = 32'h0;
    idle_inputs();
    step();
    step();
    @(negedge clk);
    check("reset_state", {63'h0, dbg_state}, 65'd0);
    check_all_zero("reset");
    step();
    rst = 1'b0;

    // Normal fetch: arvalid in cycle 2, inst_valid and pc_en in cycle 4.
    fetch(32'h80000000, 32'h00000413, 2'b00, 0, 0, 0);
    // Address back-pressure.
    fetch(32'h80000004, 32'h00100093, 2'b00, 3, 0, 0);
    // Read latency plus decode back-pressure for 5 cycles.
    fetch(32'h80000008, 32'h00208113, 2'b00, 0, 2, 5);
    // Bus error.
    fetch(32'h8000000C, 32'hDEADBEEF, 2'b10, 0, 0, 1);
    // Misaligned PC.
    fetch(32'h80000002, 32'h0, 2'b00, 0, 0, 0);

    // Reset mid-fetch: IDLE, REQ, then reset during WAIT.
    bus.pc_in = 32'h80000010;
    step();
    bus.imem_arready = 1'b1;
    step();
    bus.imem_arready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("pre_reset_wait", {64'h0, bus.imem_rready}, 65'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_state", {63'h0, dbg_state}, 65'd0);
    check_all_zero("post_reset");
    step();
    // REQ with a stray rvalid one cycle after release; must stay in REQ without arready.
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBADBAD02;
    @(negedge clk);
    check("stray_rvalid_req", {bus.imem_arvalid, bus.imem_araddr, bus.inst_valid, 31'h0},
          {1'b1, 32'h80000010, 1'b0, 31'h0});
    step();
    @(negedge clk);
    check("stray_rvalid_ignored", {63'h0, dbg_state}, 65'd1);
    // Finish this fetch by hand, then a fresh normal fetch.
    exp_q.push_back({1'b0, 32'h80000010, 32'h00000513});
    bus.imem_rvalid  = 1'b0;
    bus.imem_arready = 1'b1;
    step();
    bus.imem_arready = 1'b0;
    bus.imem_rvalid  = 1'b1;
    bus.imem_rdata   = 32'h00000513;
    step();
    idle_inputs();
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check("post_reset_fetch", {bus.inst_fault, bus.inst_pc, bus.inst}, {1'b0, 32'h80000010, 32'h00000513});
    step();
    idle_inputs();
    fetch(32'h80000014, 32'h00a00593, 2'b00, 0, 0, 0);

    // Random fetches.
    for (int k = 0; k < 8; k++) begin
      logic [31:0] pc;
      logic [1:0]  resp;
      pc   = 32'h80001000 + 32'($urandom_range(0, 255));
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fetch(pc, $urandom, resp, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    check("sb_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog against a stuck stimulus sequence.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
